// File: rtl/stat_uart_reporter.sv
// stat_uart_reporter: snapshots the total/correct counters on req or a periodic tick and
// sends "T=xxxxxxxx C=xxxxxxxx\r\n" on an 8N1 UART line.
module stat_uart_reporter #(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BAUD          = 115_200,
    parameter int REPORT_PERIOD = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] total,
    input  logic [31:0] correct,
    input  logic        req,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);
    localparam int BIT_DIV = CLK_FREQ / BAUD;
    localparam int BW = $clog2(BIT_DIV);
    localparam int PW = REPORT_PERIOD > 1 ? $clog2(REPORT_PERIOD) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(BIT_DIV - 1);
    localparam logic [PW-1:0] PER_LAST = PW'(REPORT_PERIOD > 0 ? REPORT_PERIOD - 1 : 0);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [4:0]    char_q, char_d;
    logic [PW-1:0] per_q, per_d;
    logic [31:0]   tot_q, cor_q;
    logic          tx_q, tx_d, busy_q, done_q;
    logic          tick, trig, load, bit_end;
    logic [31:0]   src;
    logic [2:0]    k;
    logic [3:0]    nib;
    logic [7:0]    hex, ch;

    assign tick    = REPORT_PERIOD != 0 && per_q == PER_LAST;
    assign per_d   = (REPORT_PERIOD == 0 || tick) ? '0 : per_q + 1'b1;
    assign trig    = req | tick;
    assign load    = state_q == IDLE && trig;
    assign bit_end = baud_q == BIT_LAST;

    // Characters 2..9 are total's nibbles, 13..20 are correct's, both MSB first.
    always_comb begin
        k   = char_q < 5'd11 ? 3'(char_q - 5'd2) : 3'(char_q - 5'd13);
        src = char_q < 5'd11 ? tot_q : cor_q;
        nib = 4'(src >> (5'd28 - {k, 2'b00}));
        hex = nib < 4'd10 ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
        ch  = char_q == 5'd0  ? "T" :
              char_q == 5'd1  ? "=" :
              char_q == 5'd10 ? " " :
              char_q == 5'd11 ? "C" :
              char_q == 5'd12 ? "=" :
              char_q == 5'd21 ? 8'h0D :
              char_q == 5'd22 ? 8'h0A : hex;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        char_d  = char_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (trig) begin
                    state_d = START;
                    char_d  = '0;
                end
            end
            START: if (bit_end) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (bit_end) begin
                bit_d = bit_q + 1'b1;
                if (bit_q == 3'd7) state_d = STOP;
            end
            STOP: if (bit_end) begin
                state_d = char_q == 5'd22 ? IDLE : START;
                char_d  = char_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        tx_d = state_q == START ? 1'b0 : state_q == DATA ? ch[bit_q] : 1'b1;
    end

    // Outputs are registered from the state, so the pin lags the FSM by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            char_q  <= '0;
            per_q   <= '0;
            tot_q   <= '0;
            cor_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            per_q   <= per_d;
            if (load) begin
                tot_q <= total;
                cor_q <= correct;
            end
            tx_q   <= tx_d;
            busy_q <= state_q != IDLE;
            done_q <= busy_q && state_q == IDLE;
        end
    end

    assign uart_tx = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_stat_uart_reporter.sv
// tb_stat_uart_reporter: directed and random report lines decoded by a behavioural UART
// receiver and compared to lines built from the counter values.
module tb_stat_uart_reporter;
    localparam int BD = 10;

    logic        clk = 0, rst_n = 0, rst_pn = 0, req = 0, req_p = 0;
    logic [31:0] total = 0, correct = 0;
    logic        uart_tx, busy, done, tx_p, busy_p, done_p;

    int errors = 0, checks = 0;
    int blen = 0, dcnt = 0, dbad = 0, lines = 0, pcyc = 0;
    logic pbusy = 0, pbusy_p = 0;
    int starts[$];

    stat_uart_reporter #(.CLK_FREQ(1000), .BAUD(100), .REPORT_PERIOD(0)) dut (
        .clk(clk), .rst_n(rst_n), .total(total), .correct(correct), .req(req),
        .uart_tx(uart_tx), .busy(busy), .done(done));

    stat_uart_reporter #(.CLK_FREQ(1000), .BAUD(100), .REPORT_PERIOD(2000)) dut_p (
        .clk(clk), .rst_n(rst_pn), .total(total), .correct(correct), .req(req_p),
        .uart_tx(tx_p), .busy(busy_p), .done(done_p));

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_pn) pcyc++;

    always @(negedge clk) begin
        if (busy && !pbusy) lines++;
        if (busy) blen = (pbusy ? blen : 0) + 1;
        if (done) dcnt++;
        if (done && !(pbusy && !busy)) dbad++;
        pbusy = busy;
        if (busy_p && !pbusy_p) starts.push_back(pcyc);
        pbusy_p = busy_p;
    end

    task automatic check(input string tag, input logic [183:0] got, input logic [183:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [183:0] exp_line(input logic [31:0] t, input logic [31:0] c);
        string hx = "0123456789ABCDEF";
        logic [7:0] b [23];
        logic [183:0] r = '0;
        b[0] = "T"; b[1] = "="; b[10] = " "; b[11] = "C"; b[12] = "=";
        b[21] = 8'h0D; b[22] = 8'h0A;
        for (int i = 0; i < 8; i++) begin
            b[2 + i]  = hx[(t >> (28 - 4 * i)) & 32'hF];
            b[13 + i] = hx[(c >> (28 - 4 * i)) & 32'hF];
        end
        for (int i = 0; i < 23; i++) r = {r[175:0], b[i]};
        return r;
    endfunction

    task automatic recv_line(output logic [183:0] line, output logic ok);
        logic [7:0] ch;
        int w;
        ok = 1;
        line = '0;
        for (int c = 0; c < 23; c++) begin
            w = 0;
            while (uart_tx === 1'b1 && w < 3000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 3000) begin
                ok = 0;
                return;
            end
            repeat (BD / 2) @(negedge clk);
            if (uart_tx !== 1'b0) ok = 0;
            for (int b = 0; b < 8; b++) begin
                repeat (BD) @(negedge clk);
                ch[b] = uart_tx;
            end
            repeat (BD) @(negedge clk);
            if (uart_tx !== 1'b1) ok = 0;
            line = {line[175:0], ch};
        end
    endtask

    task automatic wait_idle(output logic ok);
        int w = 0;
        while (busy !== 1'b0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        ok = w < 3000;
        @(negedge clk);
    endtask

    task automatic pulse_req();
        req = 1;
        @(negedge clk);
        req = 0;
    endtask

    task automatic do_line(input string tag, input logic [31:0] t, input logic [31:0] c,
                           input logic [183:0] exp);
        logic [183:0] l;
        logic ok, ok2;
        int d0;
        total = t;
        correct = c;
        d0 = dcnt;
        pulse_req();
        recv_line(l, ok);
        wait_idle(ok2);
        check({tag, "_line"}, l, exp);
        check({tag, "_frame"}, 184'(ok & ok2), 184'(1));
        check({tag, "_busylen"}, 184'(blen), 184'(230 * BD));
        check({tag, "_done"}, 184'(dcnt - d0), 184'(1));
    endtask

    initial begin
        logic [183:0] l, l2;
        logic ok, ok2;
        int d0, l0, bad;
        logic [31:0] t, c, t2, c2;

        repeat (3) @(negedge clk);
        check("rst_tx", 184'(uart_tx), 184'(1));
        check("rst_busy", 184'(busy), 184'(0));
        check("rst_done", 184'(done), 184'(0));
        rst_n = 1;
        rst_pn = 1;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("idle_quiet", 184'(bad), 184'(0));

        do_line("basic", 32'h000000FF, 32'h000000FE,
                {"T=000000FF C=000000FE", 8'h0D, 8'h0A});

        // Counter change and a dropped request while a line is in flight.
        total = 32'h000000FF;
        correct = 32'h000000FE;
        l0 = lines;
        pulse_req();
        fork
            recv_line(l, ok);
            begin
                repeat (100) @(negedge clk);
                total = 32'h12345678;
                pulse_req();
            end
        join
        wait_idle(ok2);
        check("frozen_line", l, {"T=000000FF C=000000FE", 8'h0D, 8'h0A});
        check("frozen_frame", 184'(ok & ok2), 184'(1));
        repeat (3000) @(negedge clk);
        check("dropped_req", 184'(lines - l0), 184'(1));

        do_line("hexaf", 32'hFFFFFFFF, 32'hA5C3000B,
                {"T=FFFFFFFF C=A5C3000B", 8'h0D, 8'h0A});

        for (int i = 0; i < 3; i++) begin
            t = $urandom;
            c = $urandom;
            do_line($sformatf("rand%0d", i), t, c, exp_line(t, c));
        end

        // Held request: the next line is taken as soon as the previous one ends.
        t = $urandom; c = $urandom; t2 = $urandom; c2 = $urandom;
        total = t;
        correct = c;
        d0 = dcnt;
        req = 1;
        recv_line(l, ok);
        total = t2;
        correct = c2;
        wait_idle(ok2);
        req = 0;
        check("b2b_first", l, exp_line(t, c));
        recv_line(l2, ok);
        wait_idle(ok2);
        check("b2b_second", l2, exp_line(t2, c2));
        check("b2b_frame", 184'(ok & ok2), 184'(1));
        check("b2b_busylen", 184'(blen), 184'(230 * BD));
        check("b2b_done", 184'(dcnt - d0), 184'(2));

        // Abort during character 5.
        total = 32'hDEADBEEF;
        correct = 32'h01234567;
        d0 = dcnt;
        pulse_req();
        repeat (5 * 10 * BD + 50) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("abort_tx", 184'(uart_tx), 184'(1));
        check("abort_busy", 184'(busy), 184'(0));
        check("abort_done", 184'(done), 184'(0));
        repeat (5) @(negedge clk);
        rst_n = 1;
        repeat (300) @(negedge clk);
        check("abort_nodone", 184'(dcnt - d0), 184'(0));
        t = $urandom;
        c = $urandom;
        do_line("after_abort", t, c, exp_line(t, c));

        check("period_count", 184'(starts.size() >= 3), 184'(1));
        if (starts.size() > 0) check("period_first", 184'(starts[0]), 184'(2001));
        for (int i = 1; i < starts.size(); i++)
            check($sformatf("period_gap%0d", i), 184'(starts[i] - starts[i-1]), 184'(4000));
        check("done_align", 184'(dbad), 184'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
